design_mux_ctrl: RTL

Front-end control stage between the Caravel user I/O pads and the array of student designs in the multi-design tapeout harness. It conditions the pad-level control inputs (design select, hold-reset, sync-inputs, external reset), sequences a clean reset whenever the selected design changes, fans the 12-bit input bus out to the designs, and returns the selected design's 12-bit output to the output pads. It feeds every design's reset and input bus and consumes every design's output bus.

---
 rtl/design_mux_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/design_mux_ctrl.sv
// Multi-design harness front end: conditions pad controls, sequences a reset on every design
// switch, fans io_in out and muxes the selected output back. Option: DESIGN_MUX_OUT_REG_EN.
module design_mux_ctrl #(
  parameter int unsigned NUM_DESIGNS = 64,
  parameter int unsigned IO_W        = 12,
  parameter int unsigned SEL_W       = 6,
  parameter int unsigned SEL_STABLE  = 4,
  parameter int unsigned RST_CYCLES  = 8
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic [IO_W-1:0]             io_in,
  input  logic [SEL_W-1:0]            des_sel,
  input  logic                        hold_reset,
  input  logic                        sync_inputs,
  input  logic                        ext_reset,
  input  logic [NUM_DESIGNS*IO_W-1:0] des_io_out,
  output logic [IO_W-1:0]             des_io_in,
  output logic [NUM_DESIGNS-1:0]      des_reset,
  output logic [IO_W-1:0]             io_out,
  output logic [SEL_W-1:0]            active_sel,
  output logic                        sel_valid
);

  localparam int unsigned RstCntW  = $clog2(RST_CYCLES + 1);
  localparam int unsigned StabCntW = $clog2(SEL_STABLE + 1);
  localparam logic [RstCntW-1:0]  RstLast  = RstCntW'(RST_CYCLES - 1);
  localparam logic [StabCntW-1:0] StabLast = StabCntW'(SEL_STABLE - 1);
  localparam logic [SEL_W:0]      NumDes   = (SEL_W + 1)'(NUM_DESIGNS);

  typedef enum logic [1:0] {StInit, StRun, StSwitch} state_e;

  logic [SEL_W-1:0]    r_sel_s1, r_sel_s2;
  logic                r_hold_s1, r_hold_s2;
  logic                r_sync_s1, r_sync_s2;
  logic                r_ext_s1, r_ext_s2;
  logic [IO_W-1:0]     r_io_s1, r_io_s2;

  state_e              r_state, w_state_next;
  logic [RstCntW-1:0]  r_rst_cnt, w_rst_cnt_next;
  logic [StabCntW-1:0] r_stab_cnt, w_stab_cnt_next;
  logic [SEL_W-1:0]    r_active_sel, w_active_sel_next;

  logic                w_run;
  logic                w_sel_valid;
  logic [IO_W-1:0]     w_sel_out;
  logic [IO_W-1:0]     w_io_out;

  // io_in chain runs regardless of sync_inputs so switching the mux never exposes stale data
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sel_s1  <= '0;
      r_sel_s2  <= '0;
      r_hold_s1 <= 1'b0;
      r_hold_s2 <= 1'b0;
      r_sync_s1 <= 1'b0;
      r_sync_s2 <= 1'b0;
      r_ext_s1  <= 1'b0;
      r_ext_s2  <= 1'b0;
      r_io_s1   <= '0;
      r_io_s2   <= '0;
    end else begin
      r_sel_s1  <= des_sel;
      r_sel_s2  <= r_sel_s1;
      r_hold_s1 <= hold_reset;
      r_hold_s2 <= r_hold_s1;
      r_sync_s1 <= sync_inputs;
      r_sync_s2 <= r_sync_s1;
      r_ext_s1  <= ext_reset;
      r_ext_s2  <= r_ext_s1;
      r_io_s1   <= io_in;
      r_io_s2   <= r_io_s1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state      <= StInit;
      r_rst_cnt    <= '0;
      r_stab_cnt   <= '0;
      r_active_sel <= '0;
    end else begin
      r_state      <= w_state_next;
      r_rst_cnt    <= w_rst_cnt_next;
      r_stab_cnt   <= w_stab_cnt_next;
      r_active_sel <= w_active_sel_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_rst_cnt_next    = r_rst_cnt;
    w_stab_cnt_next   = '0;
    w_active_sel_next = r_active_sel;
    case (r_state)
      StInit: begin
        w_active_sel_next = r_sel_s2;
        if (r_rst_cnt == RstLast) begin
          w_state_next   = StRun;
          w_rst_cnt_next = '0;
        end else begin
          w_rst_cnt_next = r_rst_cnt + 1'b1;
        end
      end
      StRun: begin
        if (r_sel_s2 != r_active_sel) begin
          if (r_stab_cnt == StabLast) begin
            w_state_next      = StSwitch;
            w_active_sel_next = r_sel_s2;
            w_rst_cnt_next    = '0;
          end else begin
            w_stab_cnt_next = r_stab_cnt + 1'b1;
          end
        end
      end
      StSwitch: begin
        if (r_rst_cnt == RstLast) begin
          w_state_next   = StRun;
          w_rst_cnt_next = '0;
        end else begin
          w_rst_cnt_next = r_rst_cnt + 1'b1;
        end
      end
      default: w_state_next = StInit;
    endcase
  end

  // An out-of-range active_sel matches no design, so every reset follows hold_reset
  always_comb begin
    w_run     = (r_state == StRun);
    w_sel_out = '0;
    des_reset = '1;
    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      if ({1'b0, r_active_sel} == (SEL_W + 1)'(i)) begin
        w_sel_out    = des_io_out[i*IO_W +: IO_W];
        des_reset[i] = !w_run || r_ext_s2;
      end else begin
        des_reset[i] = !w_run || r_hold_s2;
      end
    end
    w_sel_valid = w_run && ({1'b0, r_active_sel} < NumDes);
    w_io_out    = w_sel_valid ? w_sel_out : '0;
    des_io_in   = r_sync_s2 ? r_io_s2 : io_in;
    active_sel  = r_active_sel;
  end

`ifdef DESIGN_MUX_OUT_REG_EN
  logic [IO_W-1:0] r_io_out;
  logic            r_sel_valid;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_io_out    <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_io_out    <= w_io_out;
      r_sel_valid <= w_sel_valid;
    end
  end

  assign io_out    = r_io_out;
  assign sel_valid = r_sel_valid;
`else
  assign io_out    = w_io_out;
  assign sel_valid = w_sel_valid;
`endif

endmodule
